// File: rtl/btn_event_ctrl_if.sv
// btn_event_ctrl_if: pin/event bundle between a button-event controller and its user.
//   btn, en_mask, repeat_en    : driven by master (raw pins, per-channel enable, auto-repeat enable)
//   held, ev_valid, ev_idx,
//   ev_repeat                  : driven by slave (debounced state and event strobe)
interface btn_event_ctrl_if #(parameter int N_BTN = 8);
   localparam int IDX_W = N_BTN > 1 ? $clog2(N_BTN) : 1;
   logic [N_BTN-1:0] btn;
   logic [N_BTN-1:0] en_mask;
   logic repeat_en;
   logic [N_BTN-1:0] held;
   logic ev_valid;
   logic [IDX_W-1:0] ev_idx;
   logic ev_repeat;
   modport master(output btn, en_mask, repeat_en, input held, ev_valid, ev_idx, ev_repeat);
   modport slave(input btn, en_mask, repeat_en, output held, ev_valid, ev_idx, ev_repeat);
endinterface

// File: rtl/btn_event_ctrl.sv
// btn_event_ctrl: debounced multi-button press events with lowest-index arbitration and auto-repeat.
//   clk : clock, all state on rising edge
//   rst : asynchronous active-high reset
//   bus : btn/en_mask/repeat_en in; held/ev_valid/ev_idx/ev_repeat out
module btn_event_ctrl #(
   parameter int N_BTN = 8,
   parameter int DEB_CYC = 120000,
   parameter int ACTIVE_LOW = 1,
   parameter int REPEAT_DELAY = 6000000,
   parameter int REPEAT_PERIOD = 1200000
) (
   input logic clk,
   input logic rst,
   btn_event_ctrl_if.slave bus
);
   localparam int IDX_W = N_BTN > 1 ? $clog2(N_BTN) : 1;
   localparam int DW = DEB_CYC > 1 ? $clog2(DEB_CYC) : 1;
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD) - 1;
   localparam int RW = RMAX > 0 ? $clog2(RMAX + 1) : 1;
   // Synchronizers reset to the released pin level so reset release looks like "no change".
   localparam logic [N_BTN-1:0] REL = {N_BTN{ACTIVE_LOW != 0}};
   typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;
   state_t state, state_nxt;
   logic [N_BTN-1:0] s1, s2, lvl, held, held_d, pend, pend_nxt;
   logic [DW-1:0] dcnt [N_BTN];
   logic [IDX_W-1:0] owner, owner_nxt, sel_idx, ev_idx;
   logic [RW-1:0] rcnt, rcnt_nxt;
   logic req, req_nxt, rep_req, drop, sel_fresh, sel_rep, ev_valid, ev_repeat;

   assign lvl = (ACTIVE_LOW != 0) ? ~s2 : s2;
   assign bus.held = held;
   assign bus.ev_valid = ev_valid;
   assign bus.ev_idx = ev_idx;
   assign bus.ev_repeat = ev_repeat;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         s1 <= REL;
         s2 <= REL;
         held <= '0;
         held_d <= '0;
         for (int i = 0; i < N_BTN; i++) dcnt[i] <= '0;
      end else begin
         s1 <= bus.btn;
         s2 <= s1;
         held_d <= held;
         for (int i = 0; i < N_BTN; i++)
            if (lvl[i] == held[i]) dcnt[i] <= '0;
            else if (dcnt[i] == DW'(DEB_CYC - 1)) begin
               dcnt[i] <= '0;
               held[i] <= ~held[i];
            end else dcnt[i] <= dcnt[i] + 1'b1;
      end

   always_comb begin
      sel_idx = owner;
      for (int i = N_BTN - 1; i >= 0; i--) if (pend[i]) sel_idx = IDX_W'(i);
      sel_fresh = |pend;
      drop = state != IDLE && (!held[owner] || !bus.en_mask[owner] || !bus.repeat_en);
      // An unserved request persists in req; a fresh terminal count merges into it.
      rep_req = !drop && (req || (state == DELAY && rcnt == RW'(REPEAT_DELAY - 1))
                || (state == REPEAT && rcnt == RW'(REPEAT_PERIOD - 1)));
      sel_rep = !sel_fresh && rep_req;
      // Clear the served bit before merging new presses so a press is never lost.
      pend_nxt = ((pend & ~(sel_fresh ? (N_BTN'(1) << sel_idx) : '0)) | (held & ~held_d)) & bus.en_mask;
      state_nxt = state;
      owner_nxt = owner;
      rcnt_nxt = rcnt;
      req_nxt = rep_req && !sel_rep;
      if (sel_fresh && bus.repeat_en) begin
         state_nxt = DELAY;
         owner_nxt = sel_idx;
         rcnt_nxt = '0;
         req_nxt = 1'b0;
      end else if (drop) begin
         state_nxt = IDLE;
         rcnt_nxt = '0;
      end else if (state == DELAY) begin
         state_nxt = rcnt == RW'(REPEAT_DELAY - 1) ? REPEAT : DELAY;
         rcnt_nxt = rcnt == RW'(REPEAT_DELAY - 1) ? '0 : rcnt + 1'b1;
      end else if (state == REPEAT)
         rcnt_nxt = rcnt == RW'(REPEAT_PERIOD - 1) ? '0 : rcnt + 1'b1;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         pend <= '0;
         state <= IDLE;
         owner <= '0;
         rcnt <= '0;
         req <= 1'b0;
         ev_valid <= 1'b0;
         ev_idx <= '0;
         ev_repeat <= 1'b0;
      end else begin
         pend <= pend_nxt;
         state <= state_nxt;
         owner <= owner_nxt;
         rcnt <= rcnt_nxt;
         req <= req_nxt;
         ev_valid <= sel_fresh || sel_rep;
         if (sel_fresh || sel_rep) begin
            ev_idx <= sel_idx;
            ev_repeat <= sel_rep;
         end
      end
endmodule

// File: tb/tb_btn_event_ctrl.sv
// tb_btn_event_ctrl: scoreboard bench for btn_event_ctrl with directed scenarios and random pin activity.
module tb_btn_event_ctrl;
   localparam int N = 8, DEB = 4, RD = 10, RP = 5;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   btn_event_ctrl_if #(.N_BTN(N)) bus();
   btn_event_ctrl #(.N_BTN(N), .DEB_CYC(DEB), .ACTIVE_LOW(1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP))
      dut(.clk(clk), .rst(rst), .bus(bus.slave));

   typedef struct {int cyc; int idx; bit rep;} ev_t;
   ev_t exp_q[$], act_q[$];
   int n_cmp = 0, n_bad = 0, cyc = 0;

   // Reference model: pins delayed two samples, a channel's state flips after its level has
   // disagreed for DEB consecutive samples, presses queue up and drain lowest first, and the
   // repeat owner has an absolute due cycle that advances by RP every time it comes round.
   logic [N-1:0] ms1, ms2, mheld, mheld_d, mpend;
   int run [N];
   bit r_active, r_req;
   int r_owner, r_due;

   task automatic chk(string name, longint act, longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic model_step();
      logic [N-1:0] b, en, lv, nh, np;
      bit fresh, rep, drop, re;
      int k;
      b = bus.btn; en = bus.en_mask; re = bus.repeat_en;
      fresh = 0; rep = 0; k = 0;
      drop = r_active && (!mheld[r_owner] || !en[r_owner] || !re);
      if (mpend != 0) begin
         fresh = 1;
         for (int i = 0; i < N; i++) if (mpend[i]) begin k = i; break; end
      end else if (r_active && !drop && (r_req || cyc == r_due)) begin
         rep = 1; k = r_owner;
      end
      if (fresh || rep) exp_q.push_back('{cyc, k, rep});
      if (fresh && re) begin
         r_active = 1; r_owner = k; r_due = cyc + RD; r_req = 0;
      end else if (drop) begin
         r_active = 0; r_req = 0;
      end else if (r_active) begin
         if (cyc == r_due) begin r_req = !rep; r_due += RP; end
         else if (rep) r_req = 0;
      end
      np = mpend;
      if (fresh) np[k] = 1'b0;
      mpend = (np | (mheld & ~mheld_d)) & en;
      lv = ~ms2;
      nh = mheld;
      for (int i = 0; i < N; i++)
         if (lv[i] != mheld[i]) begin
            run[i]++;
            if (run[i] == DEB) begin nh[i] = ~nh[i]; run[i] = 0; end
         end else run[i] = 0;
      mheld_d = mheld; mheld = nh; ms2 = ms1; ms1 = b;
   endtask

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         ms1 = '1; ms2 = '1; mheld = '0; mheld_d = '0; mpend = '0;
         foreach (run[i]) run[i] = 0;
         r_active = 0; r_req = 0; r_owner = 0; r_due = 0;
         exp_q.delete();
      end else model_step();
   end

   always @(negedge clk) begin
      ev_t e;
      if (rst) begin
         chk("rst_ev_valid", bus.ev_valid, 0);
         chk("rst_ev_idx", bus.ev_idx, 0);
         chk("rst_ev_repeat", bus.ev_repeat, 0);
         chk("rst_held", bus.held, 0);
      end else begin
         chk("held", bus.held, mheld);
         if (bus.ev_valid) begin
            act_q.push_back('{cyc, int'(bus.ev_idx), bus.ev_repeat});
            chk("ev_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("ev_cycle", cyc, e.cyc);
               chk("ev_idx", bus.ev_idx, e.idx);
               chk("ev_repeat", bus.ev_repeat, e.rep);
            end
         end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            chk("ev_valid", bus.ev_valid, 1);
         end
      end
   end

   task automatic step(int n);
      repeat (n) @(posedge clk);
      #3;
   endtask

   initial begin
      int t0, b, seen, bad, fresh_n;
      bus.btn = '1; bus.en_mask = '1; bus.repeat_en = 1'b0;
      step(3);
      rst = 1'b0;
      step(3);
      // short glitch is filtered, a long press gives one event 8 edges later
      act_q.delete();
      bus.btn[3] = 1'b0; step(3); bus.btn[3] = 1'b1; step(20);
      chk("glitch_events", act_q.size(), 0);
      chk("glitch_held", bus.held[3], 0);
      bus.btn[3] = 1'b0; t0 = cyc; step(10); bus.btn[3] = 1'b1; step(20);
      chk("press_events", act_q.size(), 1);
      if (act_q.size() > 0) begin
         chk("press_latency", act_q[0].cyc - t0, DEB + 4);
         chk("press_idx", act_q[0].idx, 3);
         chk("press_rep", act_q[0].rep, 0);
      end
      // simultaneous presses drain on consecutive cycles, lowest first
      act_q.delete();
      bus.btn[0] = 1'b0; bus.btn[5] = 1'b0; step(15);
      chk("cont_events", act_q.size(), 2);
      if (act_q.size() == 2) begin
         chk("cont_gap", act_q[1].cyc - act_q[0].cyc, 1);
         chk("cont_first", act_q[0].idx, 0);
         chk("cont_second", act_q[1].idx, 5);
      end
      bus.btn[0] = 1'b1; bus.btn[5] = 1'b1; step(15);
      // masked channel debounces but never raises an event, even once unmasked
      act_q.delete();
      bus.en_mask[2] = 1'b0; bus.btn[2] = 1'b0; step(15);
      chk("mask_held", bus.held[2], 1);
      bus.en_mask[2] = 1'b1; step(15);
      chk("mask_events", act_q.size(), 0);
      bus.btn[2] = 1'b1; step(15);
      // auto-repeat cadence and stop on release
      act_q.delete();
      bus.repeat_en = 1'b1; bus.btn[4] = 1'b0; step(40);
      chk("rep_enough", act_q.size() >= 4, 1);
      for (int j = 1; j < 4; j++)
         if (act_q.size() > j) begin
            chk("rep_gap", act_q[j].cyc - act_q[0].cyc, RD + (j - 1) * RP);
            chk("rep_flag", act_q[j].rep, 1);
            chk("rep_idx", act_q[j].idx, 4);
         end
      bus.btn[4] = 1'b1; step(12);
      act_q.delete(); step(20);
      chk("rep_stop", act_q.size(), 0);
      // owner hand-off
      bus.btn[4] = 1'b0; step(30);
      act_q.delete();
      bus.btn[6] = 1'b0; step(40);
      seen = 0; bad = 0;
      foreach (act_q[j]) begin
         if (seen && act_q[j].idx != 6) bad++;
         if (!act_q[j].rep && act_q[j].idx == 6) seen = 1;
      end
      chk("handoff_fresh", seen, 1);
      chk("handoff_owner", bad, 0);
      bus.btn[4] = 1'b1; bus.btn[6] = 1'b1; step(20);
      // reset during repeat with the button still down
      bus.btn[1] = 1'b0; step(30);
      rst = 1'b1; #1;
      chk("async_ev_valid", bus.ev_valid, 0);
      chk("async_held", bus.held, 0);
      chk("async_ev_idx", bus.ev_idx, 0);
      step(2);
      rst = 1'b0; t0 = cyc; act_q.delete(); step(30);
      fresh_n = 0;
      foreach (act_q[j]) if (!act_q[j].rep) fresh_n++;
      chk("rst_fresh_count", fresh_n, 1);
      if (act_q.size() > 0) chk("rst_latency", act_q[0].cyc - t0, DEB + 4);
      bus.btn[1] = 1'b1; step(20);
      // random pin activity, masks and repeat enable
      for (int n = 0; n < 2500; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            b = $urandom_range(0, N - 1);
            bus.btn[b] = ~bus.btn[b];
         end
         if ($urandom_range(0, 99) == 0) bus.en_mask = $urandom_range(0, 1) ? '1 : N'($urandom);
         if ($urandom_range(0, 199) == 0) bus.repeat_en = ~bus.repeat_en;
         step(1);
      end
      bus.btn = '1; bus.en_mask = '1; step(60);
      chk("drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
